// File: rtl/omsp_spm_key_reader.sv
// rtl/omsp_spm_key_reader.sv - SPM key-select initiator: shadows one SM key and streams it as 16-bit words
// Optional: SPM_KEY_READER_WIPE_EN clears the shadow after use and zeroes word_out/word_idx when idle.
module omsp_spm_key_reader #(
    parameter int KEY_BITS     = 64,
    parameter int KEY_IDX_SIZE = 2
) (
    input  logic                    mclk,
    input  logic                    puc_rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [15:0]             sm_id,
    output logic [15:0]             spm_key_select,
    input  logic                    spm_key_select_valid,
    input  logic [0:KEY_BITS-1]     key_out,
    output logic [15:0]             word_out,
    output logic [KEY_IDX_SIZE-1:0] word_idx,
    output logic                    word_valid,
    input  logic                    word_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    error
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SELECT = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [KEY_IDX_SIZE-1:0] LAST_IDX = KEY_IDX_SIZE'(KEY_BITS / 16 - 1);

    state_t                  state;
    logic [15:0]             id_q;
    logic [0:KEY_BITS-1]     shadow;
    logic [KEY_IDX_SIZE-1:0] cnt;
    logic [15:0]             cur_word;

    // Bit 0 of the key is its MSB, so word 0 is shadow[0:15] read MSB-first.
    assign cur_word       = shadow[{cnt, 4'b0000} +: 16];
    assign spm_key_select = (state == S_SELECT) ? id_q : 16'h0000;
    assign word_valid     = (state == S_STREAM);
    assign busy           = (state != S_IDLE);

`ifdef SPM_KEY_READER_WIPE_EN
    assign word_out = word_valid ? cur_word : 16'h0000;
    assign word_idx = word_valid ? cnt : '0;
`else
    assign word_out = cur_word;
    assign word_idx = cnt;
`endif

    always_ff @(posedge mclk or negedge puc_rst_n) begin
        if (!puc_rst_n) begin
            state  <= S_IDLE;
            id_q   <= 16'h0000;
            shadow <= '0;
            cnt    <= '0;
            done   <= 1'b0;
            error  <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        id_q  <= sm_id;
                        state <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (spm_key_select_valid) begin
                        shadow <= key_out;
                        cnt    <= '0;
                        state  <= S_STREAM;
                    end else begin
                        error <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                S_STREAM: begin
                    // A word taken in the abort cycle still advances the counter.
                    if (word_ready && cnt != LAST_IDX) begin
                        cnt <= cnt + 1'b1;
                    end
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (word_ready && cnt == LAST_IDX) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
`ifdef SPM_KEY_READER_WIPE_EN
            if (abort || state == S_DONE) begin
                shadow <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_omsp_spm_key_reader.sv
// tb/tb_omsp_spm_key_reader.sv - self-checking bench for omsp_spm_key_reader (KEY_BITS=64)
module tb_omsp_spm_key_reader;

    localparam int N = 4;

    logic        mclk = 1'b0;
    logic        puc_rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] sm_id = 16'h0000;
    logic [15:0] spm_key_select;
    logic        spm_key_select_valid = 1'b0;
    logic [0:63] key_out = '0;
    logic [15:0] word_out;
    logic [1:0]  word_idx;
    logic        word_valid;
    logic        word_ready = 1'b0;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    omsp_spm_key_reader #(.KEY_BITS(64), .KEY_IDX_SIZE(2)) dut (
        .mclk                 (mclk),
        .puc_rst_n            (puc_rst_n),
        .start                (start),
        .abort                (abort),
        .sm_id                (sm_id),
        .spm_key_select       (spm_key_select),
        .spm_key_select_valid (spm_key_select_valid),
        .key_out              (key_out),
        .word_out             (word_out),
        .word_idx             (word_idx),
        .word_valid           (word_valid),
        .word_ready           (word_ready),
        .busy                 (busy),
        .done                 (done),
        .error                (error)
    );

    always #5 mclk = ~mclk;

    typedef struct {
        logic [63:0]       key;
        logic [15:0]       id;
        bit                valid;
        int                stall_word;
        int                stall_len;
        logic [0:3][15:0]  w;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge mclk);
        #1;
    endtask

    // Reference: word i of a key is the i-th 16-bit slice counted from the MSB.
    function automatic logic [15:0] key_word(input logic [63:0] k, input int i);
        return 16'(k >> (48 - 16 * i));
    endfunction

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_wv"},   64'(word_valid),     64'd0);
        chk({tag, "_busy"}, 64'(busy),           64'd0);
        chk({tag, "_done"}, 64'(done),           64'd0);
        chk({tag, "_err"},  64'(error),          64'd0);
        chk({tag, "_ks"},   64'(spm_key_select), 64'd0);
    endtask

    task automatic run_txn(input logic [63:0] key, input logic [15:0] id, input bit valid,
                           input int stall_word, input int stall_len, input bit rand_ready,
                           input logic [0:3][15:0] exp_w);
        int  k;
        int  cyc;
        int  stall;
        int  guard;
        bit  r;
        key_out = key;
        sm_id = id;
        spm_key_select_valid = valid;
        start = 1'b1;
        word_ready = 1'b0;
        tick;
        cyc = 1;
        start = 1'b0;
        sm_id = 16'($urandom);
        chk("sel_busy", 64'(busy), 64'd1);
        chk("sel_id", 64'(spm_key_select), 64'(id));
        chk("sel_wv", 64'(word_valid), 64'd0);
        tick;
        cyc = 2;
        if (!valid) begin
            chk("inv_err", 64'(error), 64'd1);
            chk("inv_busy", 64'(busy), 64'd0);
            chk("inv_wv", 64'(word_valid), 64'd0);
            tick;
            chk("inv_err_pulse", 64'(error), 64'd0);
            return;
        end
        // Key source changes after SELECT must not reach the stream.
        key_out = {$urandom, $urandom};
        spm_key_select_valid = 1'($urandom);
        chk("str_ks", 64'(spm_key_select), 64'd0);
        k = 0;
        stall = 0;
        guard = 0;
        while (k < N && guard < 100) begin
            chk("str_wv", 64'(word_valid), 64'd1);
            chk("str_word", 64'(word_out), 64'(exp_w[k]));
            chk("str_idx", 64'(word_idx), 64'(k));
            chk("str_busy", 64'(busy), 64'd1);
            chk("str_done", 64'(done), 64'd0);
            if (rand_ready) r = ($urandom_range(0, 2) != 0);
            else if (k == stall_word && stall < stall_len) r = 1'b0;
            else r = 1'b1;
            if (!r) stall++;
            word_ready = r;
            tick;
            cyc++;
            guard++;
            if (r) k++;
        end
        chk("str_all_words", 64'(k), 64'(N));
        word_ready = 1'b0;
        chk("done_pulse", 64'(done), 64'd1);
        chk("done_busy", 64'(busy), 64'd1);
        chk("done_wv", 64'(word_valid), 64'd0);
        chk("done_cycle", 64'(cyc), 64'(2 + N + stall));
        tick;
        chk("post_done", 64'(done), 64'd0);
        chk("post_busy", 64'(busy), 64'd0);
`ifdef SPM_KEY_READER_WIPE_EN
        chk("post_word_wiped", 64'(word_out), 64'd0);
        chk("post_idx_wiped", 64'(word_idx), 64'd0);
`else
        chk("post_word_held", 64'(word_out), 64'(exp_w[N-1]));
        chk("post_idx_held", 64'(word_idx), 64'(N - 1));
`endif
    endtask

    initial begin
        logic [63:0]      rk;
        logic [0:3][15:0] rw;

        tbl[0].key = 64'h0123_4567_89AB_CDEF; tbl[0].id = 16'h0003; tbl[0].valid = 1'b1;
        tbl[0].stall_word = -1; tbl[0].stall_len = 0;
        tbl[0].w = {16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
        tbl[1].key = 64'hFFFF_0000_AAAA_5555; tbl[1].id = 16'h0042; tbl[1].valid = 1'b0;
        tbl[1].stall_word = -1; tbl[1].stall_len = 0;
        tbl[1].w = {16'h0000, 16'h0000, 16'h0000, 16'h0000};
        tbl[2].key = 64'h0123_4567_89AB_CDEF; tbl[2].id = 16'h0003; tbl[2].valid = 1'b1;
        tbl[2].stall_word = 1; tbl[2].stall_len = 3;
        tbl[2].w = {16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
        tbl[3].key = 64'hDEAD_BEEF_0001_8000; tbl[3].id = 16'hFFFF; tbl[3].valid = 1'b1;
        tbl[3].stall_word = 3; tbl[3].stall_len = 2;
        tbl[3].w = {16'hDEAD, 16'hBEEF, 16'h0001, 16'h8000};

        repeat (2) @(posedge mclk);
        #1;
        chk_idle_outputs("reset");
        chk("reset_word", 64'(word_out), 64'd0);
        chk("reset_idx", 64'(word_idx), 64'd0);
        puc_rst_n = 1'b1;
        tick;

        for (int i = 0; i < 4; i++) begin
            run_txn(tbl[i].key, tbl[i].id, tbl[i].valid, tbl[i].stall_word,
                    tbl[i].stall_len, 1'b0, tbl[i].w);
        end

        // start and abort together in IDLE
        start = 1'b1; abort = 1'b1; sm_id = 16'h0007;
        tick;
        start = 1'b0; abort = 1'b0;
        chk_idle_outputs("start_abort");
        tick;
        chk("start_abort_busy2", 64'(busy), 64'd0);

        // abort during word 2
        key_out = 64'h1111_2222_3333_4444; sm_id = 16'h0005; spm_key_select_valid = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0; word_ready = 1'b1;
        tick; tick; tick;
        chk("abort_at_idx2", 64'(word_idx), 64'd2);
        chk("abort_at_word2", 64'(word_out), 64'h3333);
        abort = 1'b1; word_ready = 1'b0;
        tick;
        abort = 1'b0;
        chk_idle_outputs("abort");
        tick;
        chk("abort_no_done", 64'(done), 64'd0);

        // start during STREAM is ignored
        key_out = 64'hA0A1_B0B1_C0C1_D0D1; sm_id = 16'h0009; spm_key_select_valid = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        chk("ign_w0", 64'(word_out), 64'hA0A1);
        start = 1'b1; sm_id = 16'h0055; word_ready = 1'b1;
        tick;
        start = 1'b0;
        chk("ign_ks", 64'(spm_key_select), 64'd0);
        chk("ign_idx1", 64'(word_idx), 64'd1);
        tick; tick; tick;
        chk("ign_done", 64'(done), 64'd1);
        word_ready = 1'b0;
        tick;
        chk("ign_idle_busy", 64'(busy), 64'd0);
        tick;
        chk("ign_no_queue", 64'(busy), 64'd0);

        // reset asserted mid-stream during word 1
        key_out = 64'h0123_4567_89AB_CDEF; sm_id = 16'h0003; spm_key_select_valid = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0; word_ready = 1'b1;
        tick; tick;
        chk("rst_pre_idx", 64'(word_idx), 64'd1);
        word_ready = 1'b0;
        puc_rst_n = 1'b0;
        #1;
        chk_idle_outputs("rst_mid");
        chk("rst_mid_word", 64'(word_out), 64'd0);
        chk("rst_mid_idx", 64'(word_idx), 64'd0);
        @(negedge mclk);
        puc_rst_n = 1'b1;
        tick;
        run_txn(tbl[0].key, tbl[0].id, 1'b1, -1, 0, 1'b0, tbl[0].w);

        // randomized transactions against the word-slicing reference
        for (int t = 0; t < 24; t++) begin
            rk = {$urandom, $urandom};
            for (int i = 0; i < N; i++) rw[i] = key_word(rk, i);
            run_txn(rk, 16'($urandom), ($urandom_range(0, 4) != 0), -1, 0, 1'b1, rw);
            repeat ($urandom_range(0, 2)) tick;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
